// File: rtl/glb_psum_accum_if.sv
// -----------------------------------------------------------------------------
// glb_psum_accum_if
// Bundles the signals of the psum global-buffer bank other than clock and reset.
//   router side : write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum, accum_en
//   control     : clear_start, drain_start, drain_base, drain_len
//   drain side  : out_data, out_valid, out_ready
//   status      : busy, done, err_drop
// The master modport drives the requests. The slave modport is the bank itself.
// -----------------------------------------------------------------------------
interface glb_psum_accum_if #(
   parameter int DATA_BITWIDTH = 16,
   parameter int ADDR_BITWIDTH = 10,
   parameter int LEN_BITWIDTH  = 11
);
   logic                     write_en_glb_psum;
   logic [ADDR_BITWIDTH-1:0] w_addr_glb_psum;
   logic [DATA_BITWIDTH-1:0] w_data_glb_psum;
   logic                     accum_en;
   logic                     clear_start;
   logic                     drain_start;
   logic [ADDR_BITWIDTH-1:0] drain_base;
   logic [LEN_BITWIDTH-1:0]  drain_len;
   logic [DATA_BITWIDTH-1:0] out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic                     busy;
   logic                     done;
   logic                     err_drop;

   modport master (
      output write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum, accum_en,
      output clear_start, drain_start, drain_base, drain_len, out_ready,
      input  out_data, out_valid, busy, done, err_drop
   );

   modport slave (
      input  write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum, accum_en,
      input  clear_start, drain_start, drain_base, drain_len, out_ready,
      output out_data, out_valid, busy, done, err_drop
   );
endinterface

// File: rtl/glb_psum_accum.sv
// -----------------------------------------------------------------------------
// glb_psum_accum
// Psum global-buffer bank placed after the cluster psum router. Router writes
// are accumulated into on-chip storage through a two-stage read-modify-write
// pipeline. A control FSM zeroes the whole bank (clear). It also streams a
// window of words out over a valid/ready port (drain).
//
// Ports
//   clk    : clock. All logic runs on the rising edge.
//   reset  : synchronous, active-high. Clears control state only. Memory
//            contents survive reset.
//   bus    : glb_psum_accum_if.slave, which carries:
//            write_en_glb_psum/w_addr_glb_psum/w_data_glb_psum/accum_en
//                     router write stream. accum_en=1 adds, accum_en=0 overwrites.
//            clear_start  pulse that zeroes all DEPTH words
//            drain_start  pulse that drains drain_len words from drain_base
//                         (address wraps modulo DEPTH)
//            out_data/out_valid/out_ready   drain handshake
//            busy     FSM active, start pending, or pipeline non-empty
//            done     one-cycle pulse at the end of a clear or a drain
//            err_drop sticky flag: a router write arrived outside IDLE
// -----------------------------------------------------------------------------
module glb_psum_accum #(
   parameter int DATA_BITWIDTH = 16,
   parameter int ADDR_BITWIDTH = 10,
   parameter int LEN_BITWIDTH  = 11
) (
   input  logic            clk,
   input  logic            reset,
   glb_psum_accum_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_BITWIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_DRAIN_RD,
      S_DRAIN_OUT
   } state_t;

   // Two's complement add that wraps modulo 2^DATA_BITWIDTH. There is no saturation.
   function automatic logic signed [DATA_BITWIDTH-1:0] wrap_add(
      input logic signed [DATA_BITWIDTH-1:0] a,
      input logic signed [DATA_BITWIDTH-1:0] b
   );
      return a + b;
   endfunction

   // Storage
   logic signed [DATA_BITWIDTH-1:0] r_mem [DEPTH];

   // Control state
   state_t                   r_state;
   logic                     r_vld_p1;
   logic                     r_clr_pend;
   logic                     r_drn_pend;
   logic [LEN_BITWIDTH-1:0]  r_idx;
   logic                     r_out_valid;
   logic                     r_done;
   logic                     r_err_drop;

   // Datapath registers (no reset)
   logic [ADDR_BITWIDTH-1:0]        r_addr_p1;
   logic signed [DATA_BITWIDTH-1:0] r_data_p1;
   logic                            r_acc_p1;
   logic signed [DATA_BITWIDTH-1:0] r_rd_p1;
   logic [ADDR_BITWIDTH-1:0]        r_base;
   logic [LEN_BITWIDTH-1:0]         r_len;

   // Combinational nets
   logic                            w_idle;
   logic                            w_accept;
   logic                            w_pipe_busy;
   logic                            w_clr_req;
   logic                            w_drn_req;
   logic                            w_drn_new;
   logic [LEN_BITWIDTH-1:0]         w_len_sel;
   logic [LEN_BITWIDTH-1:0]         w_idx_inc;
   logic [ADDR_BITWIDTH-1:0]        w_drain_addr;
   logic signed [DATA_BITWIDTH-1:0] w_new_p1;
   logic                            w_fwd;
   logic                            w_we;
   logic [ADDR_BITWIDTH-1:0]        w_waddr;
   logic signed [DATA_BITWIDTH-1:0] w_wdata;

   assign w_idle      = (r_state == S_IDLE);
   assign w_accept    = bus.write_en_glb_psum && w_idle;
   // A start waits until no accepted write is still in flight. This includes
   // a write accepted in this same cycle.
   assign w_pipe_busy = r_vld_p1 || w_accept;

   // While a start is pending, any further start is ignored. Clear wins over a new drain.
   assign w_clr_req = w_idle && (r_clr_pend || (bus.clear_start && !r_drn_pend));
   assign w_drn_req = w_idle && !w_clr_req && (r_drn_pend || bus.drain_start);
   assign w_drn_new = w_drn_req && !r_drn_pend;
   assign w_len_sel = r_drn_pend ? r_len : bus.drain_len;

   assign w_idx_inc    = r_idx + LEN_BITWIDTH'(1);
   assign w_drain_addr = r_base + r_idx[ADDR_BITWIDTH-1:0];

   // Stage 2: combine the read data with the registered input word
   assign w_new_p1 = r_acc_p1 ? wrap_add(r_rd_p1, r_data_p1) : r_data_p1;
   // Stage 2 writes the same word that stage 1 reads now, so bypass the stale memory value
   assign w_fwd    = r_vld_p1 && (r_addr_p1 == bus.w_addr_glb_psum);

   // Clear and the accumulate write-back never overlap. Clear starts only
   // when the pipeline is empty, and no writes are accepted during it.
   assign w_we    = !reset && (r_vld_p1 || (r_state == S_CLEAR));
   assign w_waddr = (r_state == S_CLEAR) ? r_idx[ADDR_BITWIDTH-1:0] : r_addr_p1;
   assign w_wdata = (r_state == S_CLEAR) ? '0 : w_new_p1;

   // Single write port and single read port. The read port serves the
   // accumulate read in IDLE and the drain read in DRAIN_RD.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
      if (w_accept) begin
         r_rd_p1 <= w_fwd ? w_new_p1 : r_mem[bus.w_addr_glb_psum];
      end else if (r_state == S_DRAIN_RD) begin
         r_rd_p1 <= r_mem[w_drain_addr];
      end
   end

   // Stage 1: capture the accepted router write and the drain window
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr_p1 <= bus.w_addr_glb_psum;
         r_data_p1 <= $signed(bus.w_data_glb_psum);
         r_acc_p1  <= bus.accum_en;
      end
      if (w_drn_new) begin
         r_base <= bus.drain_base;
         r_len  <= bus.drain_len;
      end
   end

   // Control FSM, pipeline valid and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_vld_p1    <= 1'b0;
         r_clr_pend  <= 1'b0;
         r_drn_pend  <= 1'b0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_err_drop  <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_vld_p1 <= w_accept;
         if (bus.write_en_glb_psum && !w_idle) begin
            r_err_drop <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_clr_req) begin
                  if (w_pipe_busy) begin
                     r_clr_pend <= 1'b1;
                  end else begin
                     r_clr_pend <= 1'b0;
                     r_idx      <= '0;
                     r_state    <= S_CLEAR;
                  end
               end else if (w_drn_req) begin
                  if (w_pipe_busy) begin
                     r_drn_pend <= 1'b1;
                  end else begin
                     r_drn_pend <= 1'b0;
                     r_idx      <= '0;
                     // An empty drain only produces a done pulse.
                     if (w_len_sel == '0) begin
                        r_done <= 1'b1;
                     end else begin
                        r_state <= S_DRAIN_RD;
                     end
                  end
               end
            end

            S_CLEAR: begin
               r_idx <= w_idx_inc;
               if (r_idx == LEN_BITWIDTH'(DEPTH - 1)) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end

            S_DRAIN_RD: begin
               r_out_valid <= 1'b1;
               r_state     <= S_DRAIN_OUT;
            end

            S_DRAIN_OUT: begin
               // Hold valid and data until the consumer takes the word
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_idx       <= w_idx_inc;
                  if (w_idx_inc == r_len) begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_DRAIN_RD;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_valid ? r_rd_p1 : '0;
   assign bus.busy      = !w_idle || r_vld_p1 || r_clr_pend || r_drn_pend;
   assign bus.done      = r_done;
   assign bus.err_drop  = r_err_drop;

endmodule

// File: tb/tb_glb_psum_accum.sv
// -----------------------------------------------------------------------------
// tb_glb_psum_accum
// Directed bench for the psum global-buffer bank. Inputs are driven 1 time
// unit after the rising edge. Outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_glb_psum_accum;

   logic clk;
   logic reset;

   glb_psum_accum_if #(
      .DATA_BITWIDTH(16),
      .ADDR_BITWIDTH(10),
      .LEN_BITWIDTH (11)
   ) bus ();

   glb_psum_accum #(
      .DATA_BITWIDTH(16),
      .ADDR_BITWIDTH(10),
      .LEN_BITWIDTH (11)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] got [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag, input int max_cyc, output int cyc);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < max_cyc) begin
         tick();
         cyc++;
      end
      chk(tag, {31'd0, bus.done}, 32'd1);
   endtask

   task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic acc);
      bus.write_en_glb_psum = 1'b1;
      bus.w_addr_glb_psum   = a;
      bus.w_data_glb_psum   = d;
      bus.accum_en          = acc;
      tick();
      bus.write_en_glb_psum = 1'b0;
   endtask

   // Pulses drain_start, then collects every transfer into got until done.
   // It also checks that a stalled word keeps out_valid and out_data.
   task automatic run_drain(input logic [9:0] base, input logic [10:0] len,
                            input bit toggle, input int max_cyc, output int cyc);
      bit seen_done;
      bit stalled;
      logic [15:0] held;
      got.delete();
      bus.drain_base  = base;
      bus.drain_len   = len;
      bus.drain_start = 1'b1;
      bus.out_ready   = toggle ? 1'b1 : 1'b1;
      tick();
      bus.drain_start = 1'b0;
      cyc       = 0;
      seen_done = 1'b0;
      stalled   = 1'b0;
      held      = '0;
      while (!seen_done && cyc < max_cyc) begin
         if (toggle) bus.out_ready = ~bus.out_ready;
         if (stalled) begin
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_data", {16'd0, bus.out_data}, {16'd0, held});
         end
         stalled = 1'b0;
         if (bus.out_valid === 1'b1) begin
            if (bus.out_ready) got.push_back(bus.out_data);
            else begin
               held    = bus.out_data;
               stalled = 1'b1;
            end
         end
         if (bus.done === 1'b1) seen_done = 1'b1;
         else begin
            tick();
            cyc++;
         end
      end
      chk("drain_done", {31'd0, seen_done}, 32'd1);
      bus.out_ready = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      reset                 = 1'b1;
      bus.write_en_glb_psum = 1'b0;
      bus.w_addr_glb_psum   = '0;
      bus.w_data_glb_psum   = '0;
      bus.accum_en          = 1'b0;
      bus.clear_start       = 1'b0;
      bus.drain_start       = 1'b0;
      bus.drain_base        = '0;
      bus.drain_len         = '0;
      bus.out_ready         = 1'b1;
      tick(); tick(); tick();

      // Reset state
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_data", {16'd0, bus.out_data}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_err", {31'd0, bus.err_drop}, 32'd0);
      reset = 1'b0;
      tick();

      // Clear the bank: DEPTH cycles, then a one-cycle done pulse
      bus.clear_start = 1'b1;
      tick();
      bus.clear_start = 1'b0;
      chk("clr_busy", {31'd0, bus.busy}, 32'd1);
      wait_done("clr_done", 1100, cyc);
      chk("clr_cycles", cyc, 32'd1024);
      chk("clr_busy_end", {31'd0, bus.busy}, 32'd0);
      tick();
      chk("clr_done_pulse", {31'd0, bus.done}, 32'd0);

      // Overwrite two words, then drain them
      wr(10'd5, 16'd7, 1'b0);
      wr(10'd6, 16'd3, 1'b0);
      chk("wr_busy", {31'd0, bus.busy}, 32'd1);
      tick();
      chk("wr_idle", {31'd0, bus.busy}, 32'd0);
      run_drain(10'd5, 11'd2, 1'b0, 50, cyc);
      chk("d56_n", got.size(), 32'd2);
      chk("d56_w0", {16'd0, got[0]}, 32'd7);
      chk("d56_w1", {16'd0, got[1]}, 32'd3);
      chk("d56_busy", {31'd0, bus.busy}, 32'd0);

      // Back-to-back accumulation into one address (1+2+3+4)
      wr(10'd9, 16'd1, 1'b1);
      wr(10'd9, 16'd2, 1'b1);
      wr(10'd9, 16'd3, 1'b1);
      wr(10'd9, 16'd4, 1'b1);
      run_drain(10'd9, 11'd1, 1'b0, 50, cyc);
      chk("haz_n", got.size(), 32'd1);
      chk("haz_sum", {16'd0, got[0]}, 32'd10);

      // Wrap-around: FFFF + 2 = 0001
      wr(10'd0, 16'hFFFF, 1'b0);
      wr(10'd0, 16'h0002, 1'b1);
      run_drain(10'd0, 11'd1, 1'b0, 50, cyc);
      chk("wrap_sum", {16'd0, got[0]}, 32'h0001);

      // Backpressure and address wrap: 1022, 1023, 0
      wr(10'd1022, 16'h1111, 1'b0);
      wr(10'd1023, 16'h2222, 1'b0);
      tick();
      run_drain(10'd1022, 11'd3, 1'b1, 100, cyc);
      chk("bp_n", got.size(), 32'd3);
      chk("bp_w0", {16'd0, got[0]}, 32'h1111);
      chk("bp_w1", {16'd0, got[1]}, 32'h2222);
      chk("bp_w2", {16'd0, got[2]}, 32'h0001);

      // A write during clear is dropped, and the word stays zero
      bus.clear_start = 1'b1;
      tick();
      bus.clear_start = 1'b0;
      wr(10'd5, 16'h0055, 1'b0);
      chk("drop_err", {31'd0, bus.err_drop}, 32'd1);
      wait_done("drop_clr_done", 1100, cyc);
      tick();
      run_drain(10'd5, 11'd1, 1'b0, 50, cyc);
      chk("drop_word", {16'd0, got[0]}, 32'd0);
      chk("drop_err_sticky", {31'd0, bus.err_drop}, 32'd1);

      // Zero-length drain: done on the next cycle with no output
      run_drain(10'd3, 11'd0, 1'b0, 10, cyc);
      chk("len0_cyc", cyc, 32'd0);
      chk("len0_n", got.size(), 32'd0);
      tick();
      chk("len0_done_low", {31'd0, bus.done}, 32'd0);

      // Reset during DRAIN_OUT aborts the drain
      bus.out_ready   = 1'b0;
      bus.drain_base  = 10'd5;
      bus.drain_len   = 11'd2;
      bus.drain_start = 1'b1;
      tick();
      bus.drain_start = 1'b0;
      tick();
      chk("rd_valid_pre", {31'd0, bus.out_valid}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rd_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rd_busy", {31'd0, bus.busy}, 32'd0);
      chk("rd_err", {31'd0, bus.err_drop}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("rd_no_done", {31'd0, bus.done}, 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      wr(10'd6, 16'h0ABC, 1'b0);
      run_drain(10'd6, 11'd1, 1'b0, 50, cyc);
      chk("rd_new_n", got.size(), 32'd1);
      chk("rd_new_w", {16'd0, got[0]}, 32'h0ABC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
